// File: rtl/comparador_serial_pkg.sv
// Shared codes for the bit-serial comparator: cell state encoding and FSM states.
package comparador_serial_pkg;

  localparam logic [1:0] ESTADO_A = 2'b01;  // equal so far
  localparam logic [1:0] ESTADO_B = 2'b10;  // A>B decided
  localparam logic [1:0] ESTADO_C = 2'b11;  // A<B decided

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    COMPARANDO = 2'd1,
    FIN        = 2'd2
  } fsm_e;

endpackage

// File: rtl/comparador_serial_celda.sv
// Left-to-right iterative comparison cell: consumes one bit pair, advances the {p,q} state.
module celdaTipica
  import comparador_serial_pkg::*;
(
  input  logic p,
  input  logic q,
  input  logic Ai,
  input  logic Bi,
  output logic P,
  output logic Q
);

  logic [1:0] pq_s;

  // Next state: only the "equal so far" state can still move; b and c absorb.
  always_comb begin
    pq_s = ESTADO_A;
    case ({p, q})
      ESTADO_A: begin
        if (Ai == Bi)  pq_s = ESTADO_A;
        else if (Ai)   pq_s = ESTADO_B;
        else           pq_s = ESTADO_C;
      end
      ESTADO_B: pq_s = ESTADO_B;
      ESTADO_C: pq_s = ESTADO_C;
      default:  pq_s = ESTADO_A;
    endcase
  end

  assign P = pq_s[1];
  assign Q = pq_s[0];

endmodule

// File: rtl/comparador_serial.sv
// Bit-serial unsigned magnitude comparator: feeds one celdaTipica MSB first for N cycles.
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ocupado,
  output logic         listo,
  output logic         mayor,
  output logic         menor,
  output logic         igual
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  fsm_e          estado_q;
  logic [1:0]    pq_q;
  logic [1:0]    pq_d;
  logic [N-1:0]  sa_q;
  logic [N-1:0]  sb_q;
  logic [CW-1:0] cnt_q;
  logic          ocupado_q;
  logic          listo_q;
  logic          mayor_q;
  logic          menor_q;
  logic          igual_q;

  celdaTipica u_celda (
    .p  (pq_q[1]),
    .q  (pq_q[0]),
    .Ai (sa_q[N-1]),
    .Bi (sb_q[N-1]),
    .P  (pq_d[1]),
    .Q  (pq_d[0])
  );

  // Control FSM with shift registers, bit counter, carried cell state and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      pq_q      <= ESTADO_A;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      mayor_q   <= 1'b0;
      menor_q   <= 1'b0;
      igual_q   <= 1'b0;
    end else begin
      case (estado_q)
        REPOSO: begin
          listo_q <= 1'b0;
          if (inicio) begin
            sa_q      <= A;
            sb_q      <= B;
            pq_q      <= ESTADO_A;
            cnt_q     <= CW'(N - 1);
            mayor_q   <= 1'b0;
            menor_q   <= 1'b0;
            igual_q   <= 1'b0;
            ocupado_q <= 1'b1;
            estado_q  <= COMPARANDO;
          end
        end
        COMPARANDO: begin
          // Always runs the full N bits, even once b or c is reached.
          pq_q  <= pq_d;
          sa_q  <= sa_q << 1;
          sb_q  <= sb_q << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            ocupado_q <= 1'b0;
            estado_q  <= FIN;
          end
        end
        FIN: begin
          // igual is the complement of the decided cases so exactly one flag rises.
          mayor_q  <= (pq_q == ESTADO_B);
          menor_q  <= (pq_q == ESTADO_C);
          igual_q  <= (pq_q != ESTADO_B) && (pq_q != ESTADO_C);
          listo_q  <= 1'b1;
          estado_q <= REPOSO;
        end
        default: begin
          ocupado_q <= 1'b0;
          listo_q   <= 1'b0;
          estado_q  <= REPOSO;
        end
      endcase
    end
  end

  assign ocupado = ocupado_q;
  assign listo   = listo_q;
  assign mayor   = mayor_q;
  assign menor   = menor_q;
  assign igual   = igual_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench for comparador_serial (N=8): expected flags queued at start, checked at listo.
module tb_comparador_serial;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         inicio;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ocupado;
  logic         listo;
  logic         mayor;
  logic         menor;
  logic         igual;

  typedef struct packed {
    logic [2:0] flags;   // {mayor, menor, igual}
    int         acc;     // edge at which inicio was accepted
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] last_flags;
  int         cyc;
  int         total;
  int         bad;

  comparador_serial #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .ocupado (ocupado),
    .listo   (listo),
    .mayor   (mayor),
    .menor   (menor),
    .igual   (igual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    return {a > b, a < b, a == b};
  endfunction

  // Idle cycles: no listo, results held at the last reported value.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_listo", {31'd0, listo}, 32'd0);
      chk("idle_hold", {29'd0, mayor, menor, igual}, {29'd0, last_flags});
    end
  endtask

  // One comparison. b2b: drive inicio at the current negedge (cycle right after listo).
  task automatic run_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit disturb, input bit b2b);
    exp_t e;
    bit   got;
    if (!b2b) @(negedge clk);
    inicio = 1'b1;
    A = a;
    B = b;
    e.flags = model(a, b);
    e.acc   = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    inicio = 1'b0;
    chk("ocupado_on", {31'd0, ocupado}, 32'd1);
    chk("cleared", {29'd0, mayor, menor, igual}, 32'd0);
    chk("listo_early", {31'd0, listo}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 3 * N && !got; i++) begin
      inicio = disturb && (i == 1 || i == 7);
      if (disturb) begin
        A = ~A;
        B = B + 8'd37;
      end
      @(negedge clk);
      if (listo) begin
        got = 1'b1;
        inicio = 1'b0;
        if (sb_q.size() == 0) begin
          chk("spurious_listo", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("flags", {29'd0, mayor, menor, igual}, {29'd0, e.flags});
          chk("latency", cyc - e.acc, N + 1);
          chk("ocupado_off", {31'd0, ocupado}, 32'd0);
          last_flags = e.flags;
        end
      end
    end
    inicio = 1'b0;
    if (!got) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    cyc = 0;
    total = 0;
    bad = 0;
    last_flags = 3'b000;
    rst_n = 1'b0;
    inicio = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {27'd0, ocupado, listo, mayor, menor, igual}, 32'd0);
    rst_n = 1'b1;
    idle(10);
    chk("idle_ocupado", {31'd0, ocupado}, 32'd0);

    run_cmp(8'hA5, 8'hA5, 1'b0, 1'b0);
    idle(2);
    run_cmp(8'h80, 8'h7F, 1'b0, 1'b0);
    idle(2);
    run_cmp(8'h12, 8'h13, 1'b0, 1'b0);
    idle(5);
    run_cmp(8'h3C, 8'h3B, 1'b1, 1'b0);
    idle(2);
    run_cmp(8'h01, 8'hF0, 1'b1, 1'b0);
    idle(2);

    // Abort a comparison with reset at cycle 4, then check no stale listo appears.
    @(negedge clk);
    inicio = 1'b1;
    A = 8'h5A;
    B = 8'h3C;
    @(negedge clk);
    inicio = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {27'd0, ocupado, listo, mayor, menor, igual}, 32'd0);
    sb_q.delete();
    last_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    idle(N + 3);

    run_cmp(8'h00, 8'hFF, 1'b0, 1'b0);
    run_cmp(8'hFF, 8'h00, 1'b0, 1'b1);
    run_cmp(8'h77, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_cmp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), k[0], 1'b0);
    end
    idle(3);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
